// File: rtl/result_drain.sv
// Drains the result/pass serializers of a systolic tile: one load strobe, then one shift per
// accepted column beat. Optional sticky overrun flag behind RESULT_DRAIN_OVERRUN_EN.
module result_drain #(
    parameter int SIZE       = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         pass_w_enable,
    output logic                         pass_r_enable,
    input  logic [SIZE*DATA_WIDTH-1:0]   result_matrix_serial,
    input  logic [DATA_WIDTH-1:0]        result_diagonal_serial,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [SIZE*DATA_WIDTH-1:0]   o_column,
    output logic [DATA_WIDTH-1:0]        o_diag,
    output logic [$clog2(SIZE)-1:0]      o_col_idx,
    output logic                         o_last,
    output logic [1:0]                   dbg_state_o
`ifdef RESULT_DRAIN_OVERRUN_EN
    ,
    output logic                         overrun
`endif
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         pass_w_q, pass_w_d;
    logic                         valid_q, valid_d;
    logic [SIZE*DATA_WIDTH-1:0]   column_q, column_d;
    logic [DATA_WIDTH-1:0]        diag_q, diag_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         last_q, last_d;
    logic                         capture;
    logic                         drain_done;

    // Handshake: a beat transfers on a rising edge where o_valid && o_ready; o_* hold while
    // o_valid && !o_ready. The serializer shifts on exactly the edge that captures its head.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        capture    = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                capture    = (count_q < CNT_MAX) && (!valid_q || o_ready);
                drain_done = (count_q == CNT_MAX) && (!valid_q || o_ready);
                if (capture) count_d = count_q + CNT_ONE;
                // A start landing on the final accept chains straight into the next tile.
                if (drain_done) begin
                    count_d = '0;
                    state_d = start ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        pass_w_d = (state_d == S_LOAD);
        valid_d  = valid_q;
        column_d = column_q;
        diag_d   = diag_q;
        idx_d    = idx_q;
        last_d   = last_q;
        if (capture) begin
            valid_d  = 1'b1;
            column_d = result_matrix_serial;
            diag_d   = result_diagonal_serial;
            // Serializers emit the highest column first, so indices count down.
            idx_d    = IDX_W'(CNT_MAX - CNT_ONE - count_q);
            last_d   = (count_q == CNT_MAX - CNT_ONE);
        end else if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            pass_w_q <= 1'b0;
            valid_q  <= 1'b0;
            column_q <= '0;
            diag_q   <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pass_w_q <= pass_w_d;
            valid_q  <= valid_d;
            column_q <= column_d;
            diag_q   <= diag_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

`ifdef RESULT_DRAIN_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q | (start && (state_q != S_IDLE) && !drain_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    assign busy          = (state_q != S_IDLE);
    assign pass_w_enable = pass_w_q;
    assign pass_r_enable = capture;
    assign o_valid       = valid_q;
    assign o_column      = column_q;
    assign o_diag        = diag_q;
    assign o_col_idx     = idx_q;
    assign o_last        = last_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain (SIZE=4): serializer model drives the lanes, a per-tile column
// reference fills the expected queue, and a per-cycle monitor scores beats and stalls.
module tb_result_drain;

    localparam int SIZE  = 4;
    localparam int DW    = 16;
    localparam int IDX_W = $clog2(SIZE);
    localparam int W     = SIZE*DW + DW + IDX_W + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 o_ready = 1'b0;
    logic                 busy, pass_w_enable, pass_r_enable, o_valid, o_last;
    logic [SIZE*DW-1:0]   result_matrix_serial, o_column;
    logic [DW-1:0]        result_diagonal_serial, o_diag;
    logic [IDX_W-1:0]     o_col_idx;
    logic [1:0]           dbg_state;
`ifdef RESULT_DRAIN_OVERRUN_EN
    logic                 overrun;
`endif

    always #5 clk = ~clk;

    result_drain #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .busy                   (busy),
        .pass_w_enable          (pass_w_enable),
        .pass_r_enable          (pass_r_enable),
        .result_matrix_serial   (result_matrix_serial),
        .result_diagonal_serial (result_diagonal_serial),
        .o_valid                (o_valid),
        .o_ready                (o_ready),
        .o_column               (o_column),
        .o_diag                 (o_diag),
        .o_col_idx              (o_col_idx),
        .o_last                 (o_last),
        .dbg_state_o            (dbg_state)
`ifdef RESULT_DRAIN_OVERRUN_EN
        ,
        .overrun                (overrun)
`endif
    );

    // Kernel tile waiting to be loaded, and the serializer copy shifting out high column first.
    logic [DW-1:0] kern [SIZE][SIZE];
    logic [DW-1:0] ser  [SIZE][SIZE];
    int            hd = 0;

    always @(posedge clk) begin
        if (pass_w_enable) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    ser[r][c] <= kern[r][c];
            hd <= SIZE - 1;
        end else if (pass_r_enable) begin
            hd <= hd - 1;
        end
    end

    always_comb begin
        result_matrix_serial   = '0;
        result_diagonal_serial = '0;
        if (hd >= 0 && hd < SIZE) begin
            for (int r = 0; r < SIZE; r++)
                result_matrix_serial[r*DW +: DW] = ser[r][hd];
            result_diagonal_serial = ser[hd][hd];
        end
    end

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  exp_q[$];
    int            rcnt = 0;
    bit            in_tile = 0;
    bit            prev_busy = 0;
    bit            stall_prev = 0;
    logic [W-1:0]  stall_word;

    task check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task pattern_kern();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                kern[r][c] = DW'((r << 4) | c);
    endtask

    task rand_kern();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                kern[r][c] = DW'($urandom);
    endtask

    // A tile yields columns SIZE-1 down to 0; each beat carries that column and diagonal entry.
    task push_tile();
        logic [SIZE*DW-1:0] col;
        for (int c = SIZE - 1; c >= 0; c--) begin
            for (int r = 0; r < SIZE; r++)
                col[r*DW +: DW] = kern[r][c];
            exp_q.push_back({col, kern[c][c], IDX_W'(c), (c == 0)});
        end
    endtask

    task monitor();
        if (!rst_n) begin
            exp_q.delete();
            rcnt = 0;
            in_tile = 0;
            stall_prev = 0;
            prev_busy = 0;
            return;
        end
        check("excl", pass_w_enable & pass_r_enable, 0);
        if (stall_prev)
            check("hold", {o_valid, o_column, o_diag, o_col_idx, o_last}, {1'b1, stall_word});
        if (o_valid && !o_ready) begin
            check("stall_r", pass_r_enable, 0);
            stall_prev = 1;
            stall_word = {o_column, o_diag, o_col_idx, o_last};
        end else begin
            stall_prev = 0;
        end
        if (o_valid && o_ready) begin
            if (exp_q.size() == 0) check("extra", o_valid && o_ready, 0);
            else check("beat", {o_column, o_diag, o_col_idx, o_last}, exp_q.pop_front());
        end
        if (pass_w_enable) begin
            if (in_tile) check("rcount", rcnt, SIZE);
            rcnt = 0;
            in_tile = 1;
        end
        if (pass_r_enable) rcnt++;
        if (prev_busy && !busy && in_tile) begin
            check("rcount", rcnt, SIZE);
            in_tile = 0;
            rcnt = 0;
        end
        prev_busy = busy;
    endtask

    task tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task wait_idle(input bit rnd_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            if (rnd_ready) o_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        o_ready = 1'b1;
        check("timeout_idle", n < 200, 1);
    endtask

    task wait_idx(input int idx);
        int n;
        n = 0;
        while (!(o_valid && o_col_idx == IDX_W'(idx)) && n < 50) begin
            tick();
            n++;
        end
        check("timeout_idx", n < 50, 1);
    endtask

    task launch();
        start = 1'b1;
        push_tile();
        tick();
        start = 1'b0;
    endtask

    initial begin
        int lat, nb, nw, n;

        repeat (2) @(posedge clk);
        #1;
        check("reset", {busy, pass_w_enable, pass_r_enable, o_valid, o_column, o_diag,
                        o_col_idx, o_last, dbg_state}, 0);
        rst_n = 1'b1;
        tick();

        // Basic tile with o_ready high: latency, busy length, single load strobe.
        pattern_kern();
        o_ready = 1'b1;
        launch();
        lat = -1;
        nb = 0;
        nw = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) nb++;
            if (pass_w_enable) nw++;
            if (o_valid && lat < 0) lat = i;
            tick();
        end
        check("latency", lat, 3);
        check("busy_len", nb, SIZE + 2);
        check("w_pulses", nw, 1);
        check("drained1", exp_q.size(), 0);

        // Stall the idx-2 beat for five cycles.
        rand_kern();
        launch();
        wait_idx(2);
        o_ready = 1'b0;
        repeat (5) tick();
        check("stall_idx", {o_valid, o_col_idx}, {1'b1, IDX_W'(2)});
        o_ready = 1'b1;
        wait_idle(0);
        check("drained2", exp_q.size(), 0);

        // Reset after the first beat, then a fresh tile from idx 3.
        rand_kern();
        launch();
        wait_idx(2);
        rst_n = 1'b0;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rand_kern();
        launch();
        wait_idx(3);
        wait_idle(1);
        check("drained3", exp_q.size(), 0);
`ifdef RESULT_DRAIN_OVERRUN_EN
        check("ovr_rst", overrun, 0);
`endif

        // Start on the cycle the last beat is accepted chains a second tile.
        rand_kern();
        launch();
        n = 0;
        while (!(o_valid && o_last) && n < 50) begin
            tick();
            n++;
        end
        check("timeout_last", n < 50, 1);
        rand_kern();
        launch();
        check("restart_load", {pass_w_enable, busy}, 2'b11);
        wait_idle(0);
        check("drained4", exp_q.size(), 0);
`ifdef RESULT_DRAIN_OVERRUN_EN
        check("ovr_restart", overrun, 0);
`endif

        // Start during the first beat is dropped: still exactly SIZE beats.
        rand_kern();
        launch();
        wait_idx(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(0);
        repeat (4) tick();
        check("drained5", exp_q.size(), 0);
        check("idle5", busy, 0);
`ifdef RESULT_DRAIN_OVERRUN_EN
        check("ovr_set", overrun, 1);
`endif

        // Random tiles with random backpressure.
        for (int t = 0; t < 12; t++) begin
            rand_kern();
            repeat ($urandom_range(0, 2)) tick();
            launch();
            wait_idle(1);
        end
        repeat (3) tick();
        check("drained6", exp_q.size(), 0);
`ifdef RESULT_DRAIN_OVERRUN_EN
        check("ovr_sticky", overrun, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
